// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains an 8-bit synchronous FIFO one byte per frame.
// Frame: start bit, 8 data bits LSB-first, optional parity, 1 or 2 stop bits.
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_rd_data,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CntLast = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CntPen  = CW'(CLKS_PER_BIT - 2);
    localparam logic [2:0]    StopLast = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shreg_q;
    logic            par_q;
    logic            tx_q;
    logic            rd_en_q;
    logic            busy_q;
    logic            tx_done_q;

    // Parity over all 8 bits, including the bit currently on the line.
    logic par_all;
    logic par_bit;
    assign par_all = par_q ^ shreg_q[0];
    assign par_bit = (PARITY == 2) ? ~par_all : par_all;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            rd_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            tx_done_q <= 1'b0;
        end else begin
            rd_en_q   <= 1'b0;
            tx_done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        state_q <= StFetch;
                        rd_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                StFetch: begin
                    state_q <= StLoad;
                end
                StLoad: begin
                    shreg_q <= fifo_rd_data;
                    par_q   <= 1'b0;
                    state_q <= StStart;
                    tx_q    <= 1'b0;
                    cnt_q   <= '0;
                end
                StStart: begin
                    if (cnt_q == CntLast) begin
                        state_q   <= StData;
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        tx_q      <= shreg_q[0];
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (cnt_q == CntLast) begin
                        cnt_q   <= '0;
                        par_q   <= par_all;
                        shreg_q <= {1'b0, shreg_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            bit_idx_q <= '0;
                            if (PARITY != 0) begin
                                state_q <= StParity;
                                tx_q    <= par_bit;
                            end else begin
                                state_q <= StStop;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                            tx_q      <= shreg_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StParity: begin
                    if (cnt_q == CntLast) begin
                        state_q   <= StStop;
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        tx_q      <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StStop: begin
                    // Registered pulse: raise one cycle early so it lands on the final cycle.
                    if (cnt_q == CntPen && bit_idx_q == StopLast) begin
                        tx_done_q <= 1'b1;
                    end
                    if (cnt_q == CntLast) begin
                        cnt_q <= '0;
                        if (bit_idx_q == StopLast) begin
                            bit_idx_q <= '0;
                            if (!fifo_empty) begin
                                state_q <= StFetch;
                                rd_en_q <= 1'b1;
                            end else begin
                                state_q <= StIdle;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign fifo_rd_en = rd_en_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign tx_done    = tx_done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: four parameter variants, each fed by a small FIFO model.
module tb_fifo_uart_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0] empty_w;
    logic [3:0] rd_en_w;
    logic [3:0] tx_w;
    logic [3:0] busy_w;
    logic [3:0] done_w;
    logic [7:0] rdata [4];

    // FIFO model per unit: 1-cycle registered read.
    logic [7:0]  mem [4][16];
    int unsigned wp [4];
    int unsigned rp [4];

    always_comb begin
        for (int i = 0; i < 4; i++) empty_w[i] = (rp[i] == wp[i]);
    end

    int pulses [4];
    int viol;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rd_en_w[i]) begin
                rdata[i]  <= mem[i][rp[i] % 16];
                rp[i]     <= rp[i] + 1;
                pulses[i] <= pulses[i] + 1;
                if (empty_w[i]) viol <= viol + 1;
            end
        end
    end

    fifo_uart_tx #(.CLKS_PER_BIT(16), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .fifo_empty(empty_w[0]), .fifo_rd_data(rdata[0]),
        .fifo_rd_en(rd_en_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .tx_done(done_w[0])
    );
    fifo_uart_tx #(.CLKS_PER_BIT(16), .PARITY(1), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .fifo_empty(empty_w[1]), .fifo_rd_data(rdata[1]),
        .fifo_rd_en(rd_en_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .tx_done(done_w[1])
    );
    fifo_uart_tx #(.CLKS_PER_BIT(16), .PARITY(2), .STOP_BITS(1)) u2 (
        .clk(clk), .rst(rst), .fifo_empty(empty_w[2]), .fifo_rd_data(rdata[2]),
        .fifo_rd_en(rd_en_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .tx_done(done_w[2])
    );
    fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(2)) u3 (
        .clk(clk), .rst(rst), .fifo_empty(empty_w[3]), .fifo_rd_data(rdata[3]),
        .fifo_rd_en(rd_en_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .tx_done(done_w[3])
    );

    int cpb [4] = '{16, 16, 16, 4};

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, got, got, exp, exp, $time);
        end
    endtask

    task automatic push(input int u, input logic [7:0] d);
        mem[u][wp[u] % 16] = d;
        wp[u] = wp[u] + 1;
    endtask

    // Follows one frame from the fetch strobe to the last stop cycle.
    // exp_par < 0 means no parity bit; exp_wait < 0 skips the fetch-delay check.
    task automatic check_frame(input int u, input logic [7:0] d, input int exp_par,
                               input int exp_len, input int exp_wait);
        int c, w, bad, busy_bad, done_n, done_at, j, e, got_par;
        logic [7:0] got;
        c = cpb[u];
        w = 0; bad = 0; busy_bad = 0; done_n = 0; done_at = 0; got = '0; got_par = -1;
        do begin
            @(negedge clk);
            w++;
        end while (!rd_en_w[u] && w < 1000);
        if (!rd_en_w[u]) begin
            chk("fetch_timeout", 0, 1);
            return;
        end
        if (exp_wait >= 0) chk("fetch_delay", w, exp_wait);
        if (!busy_w[u]) busy_bad++;
        @(negedge clk);
        chk("rd_en_width", int'(rd_en_w[u]), 0);
        chk("load_tx_high", int'(tx_w[u]), 1);
        if (!busy_w[u]) busy_bad++;
        @(negedge clk);
        chk("start_fall", int'(tx_w[u]), 0);
        for (int k = 0; k < exp_len; k++) begin
            if (k > 0) @(negedge clk);
            j = k / c;
            if (j == 0) e = 0;
            else if (j <= 8) e = int'(d[j-1]);
            else if (j == 9 && exp_par >= 0) e = exp_par;
            else e = 1;
            if (int'(tx_w[u]) != e) bad++;
            if (k % c == c / 2) begin
                if (j >= 1 && j <= 8) got[j-1] = tx_w[u];
                if (j == 9 && exp_par >= 0) got_par = int'(tx_w[u]);
            end
            if (!busy_w[u]) busy_bad++;
            if (done_w[u]) begin
                done_n++;
                done_at = k + 1;
            end
        end
        chk("line_bad_cycles", bad, 0);
        chk("data_byte", int'(got), int'(d));
        if (exp_par >= 0) chk("parity_bit", got_par, exp_par);
        chk("busy_low_cycles", busy_bad, 0);
        chk("tx_done_count", done_n, 1);
        chk("tx_done_cycle", done_at, exp_len);
    endtask

    typedef struct {
        int         unit;
        logic [7:0] data;
        int         par;
        int         len;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int p0, w;
        vecs[0] = '{0, 8'hA5, -1, 160};
        vecs[1] = '{1, 8'h07,  1, 176};
        vecs[2] = '{2, 8'h07,  0, 176};
        vecs[3] = '{3, 8'h3C, -1,  44};
        vecs[4] = '{1, 8'h00,  0, 176};
        vecs[5] = '{2, 8'h00,  1, 176};
        vecs[6] = '{3, 8'h81, -1,  44};

        // Reset held 3 cycles with every FIFO empty, then 3 idle cycles.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_tx", int'(tx_w), 4'hF);
            chk("rst_busy", int'(busy_w), 0);
            chk("rst_rd_en", int'(rd_en_w), 0);
            chk("rst_tx_done", int'(done_w), 0);
            if (i == 2) rst = 1'b0;
        end

        // Single frames across parameter variants.
        for (int v = 0; v < 7; v++) begin
            push(vecs[v].unit, vecs[v].data);
            check_frame(vecs[v].unit, vecs[v].data, vecs[v].par, vecs[v].len, -1);
            @(negedge clk);
            chk("idle_busy", int'(busy_w[vecs[v].unit]), 0);
            chk("idle_tx", int'(tx_w[vecs[v].unit]), 1);
        end

        // Three bytes back to back: fetch follows the stop bit immediately.
        p0 = pulses[0];
        push(0, 8'h00);
        push(0, 8'hFF);
        push(0, 8'h55);
        check_frame(0, 8'h00, -1, 160, -1);
        check_frame(0, 8'hFF, -1, 160, 1);
        check_frame(0, 8'h55, -1, 160, 1);
        @(negedge clk);
        chk("b2b_idle_busy", int'(busy_w[0]), 0);
        chk("b2b_pulses", pulses[0] - p0, 3);

        // Reset during data bit 3 of 0xA5; 0x5A must follow and 0xA5 is lost.
        p0 = pulses[0];
        push(0, 8'hA5);
        push(0, 8'h5A);
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!rd_en_w[0] && w < 1000);
        chk("rst_case_fetch_seen", int'(rd_en_w[0]), 1);
        repeat (2 + 4 * 16 + 8) @(negedge clk);
        chk("mid_bit3_level", int'(tx_w[0]), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_tx", int'(tx_w[0]), 1);
        chk("midrst_busy", int'(busy_w[0]), 0);
        chk("midrst_rd_en", int'(rd_en_w[0]), 0);
        rst = 1'b0;
        check_frame(0, 8'h5A, -1, 160, -1);
        @(negedge clk);
        chk("midrst_pulses", pulses[0] - p0, 2);

        chk("pulses_u0", pulses[0], 6);
        chk("pulses_u3", pulses[3], 2);
        chk("rd_en_while_empty", viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Read-side consumer for the team's 8-bit synchronous FIFO.
- Pops one byte at a time through the FIFO read port (rd_en / empty / registered data_out, 1-cycle read latency).
- Serializes each byte onto an asynchronous UART line: start bit, 8 data bits LSB-first, optional parity, 1 or 2 stop bits.
- Sits between the FIFO and the chip's TX pin; it is the only agent driving the FIFO's rd_en.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit period; legal range 2 or more.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_data  input  8  FIFO data_out; valid the cycle after fifo_rd_en is sampled high.
- fifo_rd_en  output  1  FIFO read strobe; exactly one cycle per byte.
- tx  output  1  serial line; idle-high.
- busy  output  1  high in every state except IDLE.
- tx_done  output  1  one-cycle pulse in the last cycle of the final stop bit.

Behaviour:
- Reset (synchronous, active-high, on the clk edge where rst=1):
  - Outputs: tx=1, fifo_rd_en=0, busy=0, tx_done=0.
  - Internal: state=IDLE, baud counter=0, bit index=0, shift register=0.
- FSM states: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1.
  - If fifo_empty=0, go to FETCH; otherwise stay in IDLE.
- FETCH (1 cycle):
  - fifo_rd_en=1 (decoded from state, no other cycle asserts it); tx=1.
  - Next state is LOAD.
- LOAD (1 cycle):
  - Capture fifo_rd_data into the shift register and clear the parity accumulator; tx=1.
  - Next state is START.
- START:
  - tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - tx = shift register bit 0 for CLKS_PER_BIT cycles per bit, 8 bits, LSB first.
  - Shift right and XOR-accumulate parity at each bit boundary.
  - After bit 7, go to PARITY if PARITY is nonzero, else to STOP.
- PARITY:
  - Lasts CLKS_PER_BIT cycles.
  - tx = XOR of the data bits for even parity; inverted XOR for odd parity.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - tx_done=1 in the final cycle.
  - Next state: FETCH if fifo_empty=0 in that cycle, else IDLE.
- Baud counter:
  - Width is clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - Reset to 0 on every state entry.
- Latency and frame length:
  - Empty deasserts in cycle N (state IDLE): fifo_rd_en is high in N+1, capture in N+2, tx falls at N+3.
  - Frame length is (10 + (PARITY?1:0) + (STOP_BITS-1)) * CLKS_PER_BIT cycles.
- Back-to-back bytes: the gap between the end of a stop bit and the next start bit is exactly 2 idle-high cycles (FETCH, LOAD).
- Empty handling:
  - fifo_rd_en is never asserted while fifo_empty=1 is the condition that selected FETCH.
  - The FIFO cannot become empty between FETCH and LOAD because this block is its sole reader.
- Writes during a frame: fifo_empty changing mid-frame has no effect until the STOP or IDLE decision point.
- Reset mid-frame:
  - tx returns to 1 in the cycle after the reset edge.
  - The popped byte is discarded and not re-read.
  - fifo_rd_en stays 0 until at least one full IDLE cycle after rst deasserts.
- tx is driven from a register; no combinational glitches on the line.

Test Plan:
1. rst=1 for 3 cycles, fifo_empty=1 -> tx=1, busy=0, fifo_rd_en=0, tx_done=0 throughout and after release.
2. Defaults, FIFO holds 0xA5:
   - fifo_rd_en pulses exactly 1 cycle; tx falls 2 cycles later.
   - Line shows 0,1,0,1,0,0,1,0,1,1, each bit held 16 cycles.
   - tx_done pulses once in cycle 160 of the frame.
3. FIFO holds 0x00, 0xFF, 0x55 with empty low throughout:
   - Exactly 3 fifo_rd_en pulses; data bytes decoded in order.
   - 2 tx-high cycles between each stop end and the next start.
   - busy stays 1 from the first FETCH to the end of the third frame.
4. PARITY=1, byte 0x07 -> parity bit 1. PARITY=2, byte 0x07 -> parity bit 0. Both give frame length 176 cycles.
5. STOP_BITS=2, CLKS_PER_BIT=4, byte 0x3C -> stop period 8 cycles high, frame 44 cycles, tx_done in the final stop cycle.
6. rst asserted during data bit 3 of 0xA5, FIFO still holding 0x5A:
   - tx=1 next cycle.
   - After release, the next frame carries 0x5A (0xA5 is lost).
   - Total fifo_rd_en pulses = 2.
